// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control unit.
// Steps each instruction through FETCH, DECODE, then the execute, memory
// and writeback states that its opcode needs. It produces the IR load
// strobe and the PC, memory, register-file and ALU-mux controls.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (returns to FETCH)
//   op         opcode from IR dout[31:26]
//   mem_ready  memory finished the current read/write this cycle
//   irwr, pcwr, pcwrcond, pcsrc, iord, memrd, memwr, regwr, regdst,
//   memtoreg, alusrca, alusrcb, aluop   datapath controls
//   retire     one-cycle pulse when an instruction completes
//   illegal    unsupported opcode seen in DECODE
//   state      current state (debug)
module mc_ctrl #(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] op,
  input  logic            mem_ready,
  output logic            irwr,
  output logic            pcwr,
  output logic            pcwrcond,
  output logic [1:0]      pcsrc,
  output logic            iord,
  output logic            memrd,
  output logic            memwr,
  output logic            regwr,
  output logic            regdst,
  output logic            memtoreg,
  output logic            alusrca,
  output logic [1:0]      alusrcb,
  output logic [1:0]      aluop,
  output logic            retire,
  output logic            illegal,
  output logic [ST_W-1:0] state
);

  localparam logic [ST_W-1:0] S_FETCH  = 4'd0;
  localparam logic [ST_W-1:0] S_DECODE = 4'd1;
  localparam logic [ST_W-1:0] S_MEMADR = 4'd2;
  localparam logic [ST_W-1:0] S_MEMRD  = 4'd3;
  localparam logic [ST_W-1:0] S_MEMWB  = 4'd4;
  localparam logic [ST_W-1:0] S_MEMWR  = 4'd5;
  localparam logic [ST_W-1:0] S_EXEC   = 4'd6;
  localparam logic [ST_W-1:0] S_RWB    = 4'd7;
  localparam logic [ST_W-1:0] S_BRANCH = 4'd8;
  localparam logic [ST_W-1:0] S_JUMP   = 4'd9;
  localparam logic [ST_W-1:0] S_IEXEC  = 4'd10;
  localparam logic [ST_W-1:0] S_IWB    = 4'd11;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;

  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_next;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  assign state = r_state;

  always_comb begin
    w_next   = S_FETCH;
    irwr     = 1'b0;
    pcwr     = 1'b0;
    pcwrcond = 1'b0;
    pcsrc    = 2'b00;
    iord     = 1'b0;
    memrd    = 1'b0;
    memwr    = 1'b0;
    regwr    = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluop    = 2'b00;
    retire   = 1'b0;
    illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        memrd   = 1'b1;
        alusrcb = 2'b01;
        // IR load and PC+4 commit only on the cycle the fetch completes.
        irwr    = mem_ready;
        pcwr    = mem_ready;
        w_next  = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_RTYPE:      w_next = S_EXEC;
          OP_LW, OP_SW:  w_next = S_MEMADR;
          OP_BEQ:        w_next = S_BRANCH;
          OP_J:          w_next = S_JUMP;
          OP_ADDI,
          OP_ORI:        w_next = S_IEXEC;
          default: begin
            // Unsupported opcode: flag it and drop the instruction.
            illegal = 1'b1;
            retire  = 1'b1;
            w_next  = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_LW)      w_next = S_MEMRD;
        else if (op == OP_SW) w_next = S_MEMWR;
        else                  w_next = S_FETCH;
      end
      S_MEMRD: begin
        iord   = 1'b1;
        memrd  = 1'b1;
        w_next = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        regwr    = 1'b1;
        memtoreg = 1'b1;
        retire   = 1'b1;
      end
      S_MEMWR: begin
        iord   = 1'b1;
        memwr  = 1'b1;
        retire = mem_ready;
        w_next = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        w_next  = S_RWB;
      end
      S_RWB: begin
        regwr  = 1'b1;
        regdst = 1'b1;
        retire = 1'b1;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsrc    = 2'b01;
        pcwrcond = 1'b1;
        retire   = 1'b1;
      end
      S_JUMP: begin
        pcsrc  = 2'b10;
        pcwr   = 1'b1;
        retire = 1'b1;
      end
      S_IEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = (op == OP_ORI) ? 2'b11 : 2'b00;
        w_next  = S_IWB;
      end
      S_IWB: begin
        regwr  = 1'b1;
        retire = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle MIPS control unit; the producer side of the instruction register's `irwr` strobe.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the `irwr`, PC, memory, register-file and ALU-mux controls.
- Consumes the opcode held in the instruction register (IR `dout[31:26]`) and a memory-ready handshake.

Parameters:
- `OP_W`, 6, opcode width.
- `ST_W`, 4, state register width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `op`  in  6  opcode from IR `dout[31:26]`; stable after IR load.
- `mem_ready`  in  1  memory completed the current read/write this cycle.
- `irwr`  out  1  IR load enable.
- `pcwr`  out  1  unconditional PC write.
- `pcwrcond`  out  1  PC write if ALU zero.
- `pcsrc`  out  2  00 = ALU result, 01 = ALUOut reg, 10 = jump target.
- `iord`  out  1  0 = PC address, 1 = ALUOut address.
- `memrd`  out  1  memory read request.
- `memwr`  out  1  memory write request.
- `regwr`  out  1  register file write.
- `regdst`  out  1  0 = rt, 1 = rd.
- `memtoreg`  out  1  0 = ALUOut, 1 = MDR.
- `alusrca`  out  1  0 = PC, 1 = A.
- `alusrcb`  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- `aluop`  out  2  00 = add, 01 = sub, 10 = funct, 11 = or.
- `retire`  out  1  one-cycle pulse when an instruction completes.
- `illegal`  out  1  unsupported opcode seen in DECODE.
- `state`  out  4  current state, for debug.

Behaviour:
- Synchronous active-high reset on `clk`: `rst`=1 at a rising edge forces state to FETCH (encoding 0). Applies mid-instruction, including while a memory wait is pending; there is no resume.
- Every output not listed in a state's row is 0 in that state.
- Outputs are decoded from state, except where gated by `mem_ready` or `op`, as noted.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, IEXEC 10, IWB 11. Encodings 12–15 go to FETCH on the next edge with all outputs 0.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, ori 001101.
- FETCH
  - `memrd`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, `aluop`=00, `pcsrc`=00.
  - `irwr` and `pcwr` equal `mem_ready`.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when `mem_ready`=1.
- DECODE
  - `alusrca`=0, `alusrcb`=11, `aluop`=00.
  - Next state: R-type → EXEC; lw/sw → MEMADR; beq → BRANCH; j → JUMP; addi/ori → IEXEC.
  - Any other opcode: `illegal`=1 for this cycle, `retire`=1, next state FETCH.
- MEMADR: `alusrca`=1, `alusrcb`=10, `aluop`=00. lw → MEMRD; sw → MEMWR.
- MEMRD: `iord`=1, `memrd`=1. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB: `regwr`=1, `memtoreg`=1, `regdst`=0, `retire`=1. Next state FETCH.
- MEMWR: `iord`=1, `memwr`=1. When `mem_ready`=1: `retire`=1, next state FETCH; otherwise holds.
- EXEC: `alusrca`=1, `alusrcb`=00, `aluop`=10. Next state RWB.
- RWB: `regwr`=1, `regdst`=1, `memtoreg`=0, `retire`=1. Next state FETCH.
- BRANCH: `alusrca`=1, `alusrcb`=00, `aluop`=01, `pcsrc`=01, `pcwrcond`=1, `retire`=1. Next state FETCH.
- JUMP: `pcsrc`=10, `pcwr`=1, `retire`=1. Next state FETCH.
- IEXEC: `alusrca`=1, `alusrcb`=10; `aluop`=00 for addi, 11 for ori. Next state IWB.
- IWB: `regwr`=1, `regdst`=0, `memtoreg`=0, `retire`=1. Next state FETCH.
- Instruction latencies from FETCH entry, with `mem_ready` always 1:
  - R-type, addi, ori: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, j: 3 cycles.
  - Each cycle of `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle.
- `irwr` is asserted only in FETCH and only together with `mem_ready`. `op` may change only after that edge, and `op` is sampled only in DECODE, MEMADR and IEXEC.
- `memrd` and `memwr` are never asserted in the same cycle.

Test Plan:
- Reset mid-instruction: assert `rst` during MEMRD with `mem_ready`=0 → next cycle state=0, `memrd`=1, `iord`=0, `regwr`=0.
- R-type add, `mem_ready`=1: state sequence 0,1,6,7,0. `irwr`=1 in cycle 0 only; `regwr`=`regdst`=`retire`=1 in cycle 3.
- lw, `mem_ready` low for 2 cycles in MEMRD: sequence 0,1,2,3,3,3,4,0. `memtoreg`=1 and `regwr`=1 in state 4; `iord`=1 throughout the MEMRD cycles.
- Fetch stall: `mem_ready`=0 for 3 cycles → `irwr`=`pcwr`=0 and state=0 for those cycles; the first `mem_ready`=1 cycle gives a single `irwr`/`pcwr` pulse.
- beq then j: beq shows `pcwrcond`=1, `pcsrc`=01 in state 8; j shows `pcwr`=1, `pcsrc`=10 in state 9. Each takes 3 cycles.
- Illegal opcode 111111: `illegal`=1 and `retire`=1 in DECODE → returns to FETCH. No `regwr`, `memwr` or `pcwrcond` asserted.
